// File: rtl/mul_arbiter.sv
// Two-port round-robin front end for a shared combinational 8x8 multiplier.
// Each accepted request gets CALC_CYCLES settle cycles, then holds its product until consumed.

module i8bit_mul (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  assign o_p = 16'(i_a) * 16'(i_b);
endmodule

module mul_arbiter #(
  parameter int CALC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_0,
  input  logic       req_valid_1,
  output logic       req_ready_0,
  output logic       req_ready_1,
  input  logic [7:0] a_0,
  input  logic [7:0] b_0,
  input  logic [7:0] a_1,
  input  logic [7:0] b_1,
  output logic       rsp_valid_0,
  output logic       rsp_valid_1,
  input  logic       rsp_ready_0,
  input  logic       rsp_ready_1,
  output logic [7:0] prod_low,
  output logic [7:0] prod_high,
  output logic       busy,
  output logic [1:0] dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // requesters hold valid (and operands) until that edge, ready never depends on ready.

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(CALC_CYCLES - 1);

  state_t      r_state;
  logic        r_prio;
  logic        r_owner;
  logic [2:0]  r_cnt;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_prod;
  logic        r_rsp_valid_0;
  logic        r_rsp_valid_1;

  logic        w_idle;
  logic        w_take;
  logic        w_grant_1;
  logic        w_rsp_ack;
  logic [15:0] w_mul;

  i8bit_mul u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_mul)
  );

  // Port 1 wins when it is alone, or when both ask and the pointer names it.
  assign w_grant_1 = req_valid_1 && (!req_valid_0 || r_prio);
  assign w_take    = req_valid_0 || req_valid_1;
  assign w_idle    = (r_state == S_IDLE) && !rst;
  assign w_rsp_ack = r_owner ? rsp_ready_1 : rsp_ready_0;

  assign req_ready_0 = w_idle && req_valid_0 && !w_grant_1;
  assign req_ready_1 = w_idle && w_grant_1;

  assign rsp_valid_0 = r_rsp_valid_0;
  assign rsp_valid_1 = r_rsp_valid_1;
  assign prod_low    = r_prod[7:0];
  assign prod_high   = r_prod[15:8];
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_prio        <= 1'b0;
      r_owner       <= 1'b0;
      r_cnt         <= 3'd0;
      r_a           <= 8'd0;
      r_b           <= 8'd0;
      r_prod        <= 16'd0;
      r_rsp_valid_0 <= 1'b0;
      r_rsp_valid_1 <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_owner <= w_grant_1;
            r_a     <= w_grant_1 ? a_1 : a_0;
            r_b     <= w_grant_1 ? b_1 : b_0;
            r_prio  <= !w_grant_1;
            r_cnt   <= CNT_LOAD;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt == 3'd0) begin
            r_prod        <= w_mul;
            r_rsp_valid_0 <= !r_owner;
            r_rsp_valid_1 <= r_owner;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_ack) begin
            r_rsp_valid_0 <= 1'b0;
            r_rsp_valid_1 <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
